// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - fetch stage states, NOP encoding and decoder opcode field codes
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // instr[6:2] major opcode codes as seen by the decoder
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    // Fetch addresses are always word aligned
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_instr_fields.sv
// rtl/fetch_unit_instr_fields.sv - combinational opcode/ctrl split of an instruction word
module fetch_unit_instr_fields (
    input  logic [31:0] instr,
    output logic [4:0]  opcode,
    output logic [3:0]  ctrl
);

    // Bits the decoder takes from elsewhere; kept here only to mark them as intentionally unread
    logic unused_bits;

    assign opcode      = instr[6:2];
    assign ctrl        = {instr[30], instr[14:12]};
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], instr[1:0]};

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage; optional FETCH_MISALIGN_CHK_EN
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [4:0]  opcode,
    output logic [3:0]  ctrl,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic         kill;
    logic [31:0]  target;
    logic         bad_redirect;
    logic         err_q;

    assign target = align_word(redirect_pc);

`ifdef FETCH_MISALIGN_CHK_EN
    assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Sticky misalignment flag; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad_redirect) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_low;

    assign bad_redirect = 1'b0;
    assign err_q        = 1'b0;
    assign unused_low   = ^redirect_pc[1:0];
`endif

    assign misalign_err = err_q;
    assign imem_req     = (state == REQ);
    assign imem_addr    = fetch_pc;

    // Fetch sequencer: request, wait for response (dropping it if a redirect made it stale), hold for decoder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            pc          <= RESET_PC;
        end else if (bad_redirect) begin
            state       <= IDLE;
            kill        <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= target;
                    end
                    if (!err_q) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    // The pulse this cycle still carries the old address, so its response must be discarded
                    state <= WAIT;
                    if (redirect_valid) begin
                        fetch_pc <= target;
                        kill     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc <= target;
                        if (imem_rvalid) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            instr       <= imem_rdata;
                            pc          <= fetch_pc;
                            fetch_pc    <= fetch_pc + 32'd4;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        fetch_pc    <= target;
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_unit_instr_fields u_fields (
        .instr  (instr),
        .opcode (opcode),
        .ctrl   (ctrl)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-programmable instruction memory
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [3:0]  ctrl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  opc;
        logic [3:0]  ctrl;
    } exp_t;

    logic [31:0] exp_addr[$];
    exp_t        exp_instr[$];
    int          acc_cyc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          resp_lat = 1;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc             (pc),
        .opcode         (opcode),
        .ctrl           (ctrl),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_i(input logic [31:0] i, input logic [31:0] p, input logic [4:0] o, input logic [3:0] c);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        e.opc   = o;
        e.ctrl  = c;
        exp_instr.push_back(e);
    endtask

    function automatic logic [31:0] word_for(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h40B5_0533;
            32'h0000_0004: return 32'h0050_0093;
            32'h0000_0008: return 32'h0020_C133;
            32'h0000_000C: return 32'h00C1_2083;
            32'h0000_0100: return 32'h0000_006F;
            32'h0000_0104: return 32'h0000_0013;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Instruction memory: one response per request, resp_lat cycles after the request cycle
    initial begin
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && imem_req) begin
                a = imem_addr;
                repeat (resp_lat) @(posedge clk);
                #1;
                imem_rvalid = 1'b1;
                imem_rdata  = word_for(a);
                @(posedge clk);
                #1;
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Monitor: compare every request and every accepted instruction against the scoreboard
    initial begin
        logic [31:0] ea;
        exp_t        ei;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (imem_req) begin
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_req_addr", imem_addr, 32'hXXXX_XXXX);
                    end else begin
                        ea = exp_addr.pop_front();
                        chk("req_addr", imem_addr, ea);
                    end
                end
                if (instr_valid && instr_ready) begin
                    n_acc++;
                    acc_cyc.push_back(cyc);
                    if (exp_instr.size() == 0) begin
                        chk("unexpected_accept_pc", pc, 32'hXXXX_XXXX);
                    end else begin
                        ei = exp_instr.pop_front();
                        chk("acc_instr", instr, ei.instr);
                        chk("acc_pc", pc, ei.pc);
                        chk("acc_opc_ctrl", {23'd0, opcode, ctrl}, {23'd0, ei.opc, ei.ctrl});
                    end
                end
            end
        end
    end

    task automatic wait_acc(input int target, input int budget);
        int k = 0;
        while (n_acc < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("wait_accept_timeout", n_acc, target);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        @(negedge clk);
        while (!instr_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic wait_req(input int budget);
        int k = 0;
        @(negedge clk);
        while (!imem_req && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("rst_opcode", {27'd0, opcode}, 32'h04);
        chk("rst_ctrl", {28'd0, ctrl}, 32'h0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

        // Sequential fetch, ready always high, 1-cycle memory
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC);
        push_i(32'h40B5_0533, 32'h0, 5'b01100, 4'b1000);
        push_i(32'h0050_0093, 32'h4, 5'b00100, 4'b0000);
        push_i(32'h0020_C133, 32'h8, 5'b01100, 4'b0100);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        rst         = 1'b0;
        wait_acc(3, 40);
        instr_ready = 1'b0;
        if (acc_cyc.size() >= 3) begin
            chk("cadence_0_1", acc_cyc[1] - acc_cyc[0], 32'd3);
            chk("cadence_1_2", acc_cyc[2] - acc_cyc[1], 32'd3);
        end else begin
            chk("cadence_count", acc_cyc.size(), 32'd3);
        end

        // Back-pressure: outputs stable and no request while held
        push_i(32'h00C1_2083, 32'hC, 5'b00000, 4'b0010);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_instr", instr, 32'h00C1_2083);
            chk("hold_pc", pc, 32'hC);
            chk("hold_no_req", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_lat = 3;
        exp_addr.push_back(32'h10);
        instr_ready = 1'b1;

        // Redirect while waiting on a slow response: stale word dropped
        wait_req(20);
        @(posedge clk);
        #1;
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        push_i(32'h0000_006F, 32'h100, 5'b11011, 4'b0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        resp_lat       = 1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_acc(5, 40);

        // Redirect in the same cycle as the response
        @(posedge clk);
        #1;
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC);
        push_i(32'h0020_C133, 32'h8, 5'b01100, 4'b0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("same_cycle_no_valid", {31'd0, instr_valid}, 32'd0);
        wait_acc(6, 40);
        instr_ready = 1'b0;

        // Redirect while holding, with ready high: handshake counts, then refetch from target
        push_i(32'h00C1_2083, 32'hC, 5'b00000, 4'b0010);
        wait_valid(20);
        @(posedge clk);
        #1;
        exp_addr.push_back(32'h100);
        push_i(32'h0000_006F, 32'h100, 5'b11011, 4'b0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        instr_ready    = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        @(negedge clk);
        chk("hold_redirect_valid_drop", {31'd0, instr_valid}, 32'd0);
        wait_valid(20);

        // Misaligned redirect
`ifdef FETCH_MISALIGN_CHK_EN
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        instr_ready    = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("misalign_err", {31'd0, misalign_err}, 32'd1);
            chk("misalign_no_req", {31'd0, imem_req}, 32'd0);
        end
`else
        @(posedge clk);
        #1;
        exp_addr.push_back(32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        instr_ready    = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        wait_valid(20);
        chk("unaligned_fetch_pc", pc, 32'h100);
        chk("unaligned_fetch_instr", instr, 32'h0000_006F);
        chk("no_misalign_err", {31'd0, misalign_err}, 32'd0);
`endif

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst_instr", instr, 32'h0000_0013);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_misalign", {31'd0, misalign_err}, 32'd0);

        repeat (2) @(posedge clk);
        chk("addr_queue_empty", exp_addr.size(), 32'd0);
        chk("instr_queue_empty", exp_instr.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
